// File: rtl/stac_tap_pkg.sv
// stac_tap_pkg: TAP state encodings, instruction codes and Cap-IR pattern shared by stac_tap_ctrl.
package stac_tap_pkg;

  typedef enum logic [3:0] {
    EX2DR = 4'h0,
    EX1DR = 4'h1,
    SHDR  = 4'h2,
    PAUDR = 4'h3,
    SELIR = 4'h4,
    UPDDR = 4'h5,
    CAPDR = 4'h6,
    SELDR = 4'h7,
    EX2IR = 4'h8,
    EX1IR = 4'h9,
    SHIR  = 4'hA,
    PAUIR = 4'hB,
    RTI   = 4'hC,
    UPDIR = 4'hD,
    CAPIR = 4'hE,
    TLR   = 4'hF
  } tapState_t;

  // BYPASS is the all-ones code at whatever IR width the controller uses.
  localparam int BYPASS_CODE = -1;
  localparam int IDCODE_CODE = 1;
  localparam int TDR_BASE    = 2;
  localparam logic [1:0] CAPIR_PAT = 2'b01;

  function automatic tapState_t tapNext(input tapState_t s, input logic tms);
    case (s)
      TLR:     return tms ? TLR   : RTI;
      RTI:     return tms ? SELDR : RTI;
      SELDR:   return tms ? SELIR : CAPDR;
      CAPDR:   return tms ? EX1DR : SHDR;
      SHDR:    return tms ? EX1DR : SHDR;
      EX1DR:   return tms ? UPDDR : PAUDR;
      PAUDR:   return tms ? EX2DR : PAUDR;
      EX2DR:   return tms ? UPDDR : SHDR;
      UPDDR:   return tms ? SELDR : RTI;
      SELIR:   return tms ? TLR   : CAPIR;
      CAPIR:   return tms ? EX1IR : SHIR;
      SHIR:    return tms ? EX1IR : SHIR;
      EX1IR:   return tms ? UPDIR : PAUIR;
      PAUIR:   return tms ? EX2IR : PAUIR;
      EX2IR:   return tms ? UPDIR : SHIR;
      UPDIR:   return tms ? SELDR : RTI;
      default: return TLR;
    endcase
  endfunction

endpackage

// File: rtl/stac_tap_fsm.sv
// stac_tap_fsm: 16-state TAP state register with registered one-flop state decodes.
module stac_tap_fsm
  import stac_tap_pkg::*;
(
  input  logic      TCLK,
  input  logic      TRESETN,
  input  logic      TMS,
  output tapState_t tapState,
  output logic      testLogicReset,
  output logic      captureDr,
  output logic      shiftDr,
  output logic      updateDr,
  output logic      captureIr,
  output logic      shiftIr,
  output logic      updateIr
);

  tapState_t nextState;

  assign nextState = tapNext(tapState, TMS);

  // Decodes are registered from nextState so each equals (tapState == X) without a decode glitch.
  always_ff @(posedge TCLK or negedge TRESETN)
    if (!TRESETN) begin
      tapState       <= TLR;
      testLogicReset <= 1'b1;
      captureDr      <= 1'b0;
      shiftDr        <= 1'b0;
      updateDr       <= 1'b0;
      captureIr      <= 1'b0;
      shiftIr        <= 1'b0;
      updateIr       <= 1'b0;
    end else begin
      tapState       <= nextState;
      testLogicReset <= nextState == TLR;
      captureDr      <= nextState == CAPDR;
      shiftDr        <= nextState == SHDR;
      updateDr       <= nextState == UPDDR;
      captureIr      <= nextState == CAPIR;
      shiftIr        <= nextState == SHIR;
      updateIr       <= nextState == UPDIR;
    end

endmodule

// File: rtl/stac_tap_ctrl.sv
// stac_tap_ctrl: TAP controller with IR, BYPASS, one-hot TDR enables and negedge TDO.
// STAC_TAP_IDCODE_EN adds the 32-bit IDCODE DR and makes IDCODE the reset instruction.
module stac_tap_ctrl
  import stac_tap_pkg::*;
#(
  parameter int          NUM_TDR    = 4,
  parameter int          IR_W       = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h0000_0001
) (
  input  logic               TCLK,
  input  logic               TRESETN,
  input  logic               TMS,
  input  logic               TDI,
  input  logic [NUM_TDR-1:0] TdrSO,
  output logic               SI,
  output logic               CaptureDR,
  output logic               ShiftDR,
  output logic               UpdateDR,
  output logic [NUM_TDR-1:0] TdrEnable,
  output logic               TDO,
  output logic               TDO_EN
);

  tapState_t       tapState;
  logic            tlr;
  logic            captureIr;
  logic            shiftIr;
  logic            updateIr;
  logic [IR_W-1:0] ir;
  logic [IR_W-1:0] irShift;
  logic            bypassReg;
  logic            selIdcode;
  logic            selBypass;
  logic            idBit;
  logic            drBit;

  stac_tap_fsm uFsm (
    .TCLK           (TCLK),
    .TRESETN        (TRESETN),
    .TMS            (TMS),
    .tapState       (tapState),
    .testLogicReset (tlr),
    .captureDr      (CaptureDR),
    .shiftDr        (ShiftDR),
    .updateDr       (UpdateDR),
    .captureIr      (captureIr),
    .shiftIr        (shiftIr),
    .updateIr       (updateIr)
  );

  assign SI = TDI;

`ifdef STAC_TAP_IDCODE_EN
  localparam logic [IR_W-1:0] irDefault = IR_W'(IDCODE_CODE);
  logic [31:0] idReg;
  assign selIdcode = ir == IR_W'(IDCODE_CODE);
  always_ff @(posedge TCLK or negedge TRESETN)
    if (!TRESETN) idReg <= '0;
    else if (CaptureDR && selIdcode) idReg <= IDCODE_VAL;
    else if (ShiftDR && selIdcode) idReg <= {TDI, idReg[31:1]};
  assign idBit = idReg[0];
`else
  localparam logic [IR_W-1:0] irDefault = IR_W'(BYPASS_CODE);
  assign selIdcode = 1'b0;
  assign idBit     = IDCODE_VAL[0];
`endif

  for (genvar i = 0; i < NUM_TDR; i++) begin : gEn
    assign TdrEnable[i] = ir == IR_W'(TDR_BASE + i);
  end

  // Anything that is neither IDCODE nor an attached TDR falls back to BYPASS.
  assign selBypass = !selIdcode && !(|TdrEnable);
  assign drBit     = selIdcode ? idBit : selBypass ? bypassReg : |(TdrSO & TdrEnable);

  always_ff @(posedge TCLK or negedge TRESETN)
    if (!TRESETN) begin
      irShift   <= '0;
      bypassReg <= 1'b0;
    end else begin
      irShift   <= captureIr ? IR_W'(CAPIR_PAT) : shiftIr ? {TDI, irShift[IR_W-1:1]} : irShift;
      bypassReg <= !selBypass ? bypassReg : CaptureDR ? 1'b0 : ShiftDR ? TDI : bypassReg;
    end

  // IR and TDO move on the falling edge so TdrEnable never changes under a DR scan edge.
  always_ff @(negedge TCLK or negedge TRESETN)
    if (!TRESETN) begin
      ir     <= irDefault;
      TDO    <= 1'b0;
      TDO_EN <= 1'b0;
    end else begin
      ir     <= tlr ? irDefault : updateIr ? irShift : ir;
      TDO    <= shiftIr ? irShift[0] : ShiftDR & drBit;
      TDO_EN <= shiftIr | ShiftDR;
    end

endmodule

// File: tb/tb_stac_tap_ctrl.sv
// tb_stac_tap_ctrl: directed IR/DR scans against a TDO scoreboard and a behavioural TDR chain.
module tb_stac_tap_ctrl;
  import stac_tap_pkg::*;

  localparam int          NUM_TDR = 4;
  localparam int          IR_W    = 4;
  localparam logic [31:0] IDV     = 32'h4BA0_0477;
`ifdef STAC_TAP_IDCODE_EN
  localparam logic [IR_W-1:0] IR_DEF = 4'h1;
`else
  localparam logic [IR_W-1:0] IR_DEF = 4'hF;
`endif

  logic               TCLK    = 1'b0;
  logic               TRESETN = 1'b0;
  logic               TMS     = 1'b1;
  logic               TDI     = 1'b0;
  logic [NUM_TDR-1:0] TdrSO;
  logic               SI;
  logic               CaptureDR;
  logic               ShiftDR;
  logic               UpdateDR;
  logic [NUM_TDR-1:0] TdrEnable;
  logic               TDO;
  logic               TDO_EN;

  stac_tap_ctrl #(.NUM_TDR(NUM_TDR), .IR_W(IR_W), .IDCODE_VAL(IDV)) dut (
    .TCLK      (TCLK),
    .TRESETN   (TRESETN),
    .TMS       (TMS),
    .TDI       (TDI),
    .TdrSO     (TdrSO),
    .SI        (SI),
    .CaptureDR (CaptureDR),
    .ShiftDR   (ShiftDR),
    .UpdateDR  (UpdateDR),
    .TdrEnable (TdrEnable),
    .TDO       (TDO),
    .TDO_EN    (TDO_EN)
  );

  always #5 TCLK = ~TCLK;

  int   tests = 0;
  int   fails = 0;
  int   capCnt, shCnt, updCnt;
  logic expQ[$];

  logic [32:0] tdrSr  [NUM_TDR];
  logic [32:0] tdrUpd [NUM_TDR];

  function automatic logic [32:0] capVal(input int i);
    return 33'h1_0F0F_A5C3 ^ 33'(i);
  endfunction

  // External TDRs: capture/shift on posedge, update on negedge, as a gasket chain would.
  always @(posedge TCLK)
    for (int i = 0; i < NUM_TDR; i++)
      if (TdrEnable[i]) begin
        if (CaptureDR) tdrSr[i] <= capVal(i);
        else if (ShiftDR) tdrSr[i] <= {SI, tdrSr[i][32:1]};
      end

  always @(negedge TCLK)
    for (int i = 0; i < NUM_TDR; i++)
      if (TdrEnable[i] && UpdateDR) tdrUpd[i] <= tdrSr[i];

  always_comb
    for (int i = 0; i < NUM_TDR; i++) TdrSO[i] = tdrSr[i][0];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic popCheck(input string tag);
    if (expQ.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed %0h expected <scoreboard empty>", tag, TDO);
    end else check(tag, 64'(TDO), 64'(expQ.pop_front()));
  endtask

  task automatic tick(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCLK);
    @(negedge TCLK);
    #1;
    capCnt += int'(CaptureDR);
    shCnt  += int'(ShiftDR);
    updCnt += int'(UpdateDR);
  endtask

  // From RTI; ends in Upd-IR just after the negedge that loads the IR.
  task automatic irScan(input logic [IR_W-1:0] code);
    for (int k = 0; k < IR_W; k++) expQ.push_back(k == 0);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    check("ir_tdo_en", 64'(TDO_EN), 64'd1);
    for (int k = 0; k < IR_W; k++) begin
      popCheck("ir_tdo");
      tick(k == IR_W - 1, code[k]);
    end
    tick(1, 0);
  endtask

  // From RTI back to RTI; expected TDO bits must already be queued.
  task automatic drScan(input string tag, input int n, input logic [63:0] data);
    tick(1, 0); tick(0, 0); tick(0, 0);
    check("dr_tdo_en", 64'(TDO_EN), 64'd1);
    for (int k = 0; k < n; k++) begin
      popCheck(tag);
      tick(k == n - 1, data[k]);
    end
    tick(1, 0); tick(0, 0);
  endtask

  initial begin
    logic [32:0] cap;
    logic [32:0] saved;
    logic [7:0]  bpData;
    logic [31:0] idData;
    capCnt = 0; shCnt = 0; updCnt = 0;
    #12;
    check("rst_state", 64'(dut.tapState), 64'(TLR));
    check("rst_tdo", 64'(TDO), 64'd0);
    check("rst_tdo_en", 64'(TDO_EN), 64'd0);
    check("rst_strobes", 64'({CaptureDR, ShiftDR, UpdateDR}), 64'd0);
    check("rst_tdr_en", 64'(TdrEnable), 64'd0);
    check("rst_ir", 64'(dut.ir), 64'(IR_DEF));
    TRESETN = 1'b1;
    @(negedge TCLK);
    #1;
    tick(0, 0);
    check("rti_state", 64'(dut.tapState), 64'(RTI));
    irScan(4'b0011);
    check("ir3_tdr_en", 64'(TdrEnable), 64'b0010);
    tick(0, 0);
    cap = capVal(1);
    for (int k = 0; k < 33; k++) expQ.push_back(cap[k]);
    capCnt = 0; shCnt = 0; updCnt = 0;
    drScan("tdr1_tdo", 33, 64'h1_2345_6789);
    check("tdr1_cap_cycles", 64'(capCnt), 64'd1);
    check("tdr1_shift_cycles", 64'(shCnt), 64'd33);
    check("tdr1_upd_cycles", 64'(updCnt), 64'd1);
    check("tdr1_update_val", 64'(tdrUpd[1]), 64'h1_2345_6789);
    irScan(4'hF);
    check("byp_tdr_en", 64'(TdrEnable), 64'd0);
    tick(0, 0);
    bpData = 8'hA5;
    expQ.push_back(1'b0);
    for (int k = 0; k < 7; k++) expQ.push_back(bpData[k]);
    drScan("bypass_tdo", 8, 64'(bpData));
    irScan(4'h1);
    tick(0, 0);
    idData = 32'hC3C3_1E1E;
`ifdef STAC_TAP_IDCODE_EN
    for (int k = 0; k < 32; k++) expQ.push_back(IDV[k]);
`else
    expQ.push_back(1'b0);
    for (int k = 0; k < 31; k++) expQ.push_back(idData[k]);
`endif
    drScan("idcode_tdo", 32, 64'(idData));
    irScan(4'h2);
    check("ir2_tdr_en", 64'(TdrEnable), 64'b0001);
    tick(0, 0);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0); tick(1, 1); tick(0, 0);
    check("pause_ir_state", 64'(dut.tapState), 64'(PAUIR));
    check("pause_ir_tdo_en", 64'(TDO_EN), 64'd0);
    for (int k = 0; k < 5; k++) tick(1, 0);
    check("tms5_state", 64'(dut.tapState), 64'(TLR));
    check("tms5_ir", 64'(dut.ir), 64'(IR_DEF));
    check("tms5_tdr_en", 64'(TdrEnable), 64'd0);
    tick(0, 0);
    irScan(4'b0011);
    tick(0, 0);
    saved = tdrUpd[1];
    tick(1, 0); tick(0, 0); tick(0, 0);
    tick(0, 1); tick(0, 1); tick(0, 1);
    check("mid_shift_state", 64'(dut.tapState), 64'(SHDR));
    TRESETN = 1'b0;
    #1;
    check("abort_state", 64'(dut.tapState), 64'(TLR));
    check("abort_tdo", 64'(TDO), 64'd0);
    check("abort_tdo_en", 64'(TDO_EN), 64'd0);
    check("abort_strobes", 64'({CaptureDR, ShiftDR, UpdateDR}), 64'd0);
    check("abort_ir", 64'(dut.ir), 64'(IR_DEF));
    check("abort_tdr_en", 64'(TdrEnable), 64'd0);
    TRESETN = 1'b1;
    updCnt = 0;
    tick(1, 0); tick(1, 0); tick(1, 0);
    check("abort_no_update", 64'(updCnt), 64'd0);
    check("abort_tdr_held", 64'(tdrUpd[1]), 64'(saved));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish by 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
